// File: rtl/cmp_arb_pkg.sv
// Shared definitions for the EXU compare arbiter: compare function codes,
// port identifier type and default datapath width.
package cmp_arb_pkg;

   localparam int unsigned CMP_W = 32;

   localparam logic [2:0] CMP_EQ   = 3'b000;
   localparam logic [2:0] CMP_NE   = 3'b001;
   localparam logic [2:0] CMP_GE   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b011;
   localparam logic [2:0] CMP_GTU  = 3'b100;
   localparam logic [2:0] CMP_LTU  = 3'b101;
   localparam logic [2:0] CMP_GEU  = 3'b110;
   localparam logic [2:0] CMP_OVF  = 3'b111;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/cmp_core.sv
// Combinational 32-bit comparator: one subtractor a-b producing Z/N/V/C
// flags, with the compare function selecting the flag combination.
module cmp_core
   import cmp_arb_pkg::*;
#(
   parameter int unsigned W = CMP_W
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [2:0]   fn_i,
   output logic         res_o
);

   logic [W:0] sub;
   logic       flag_z;
   logic       flag_n;
   logic       flag_v;
   logic       flag_c;

   // a - b as a + ~b + 1; carry out set means no borrow (a >= b unsigned)
   assign sub    = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
   assign flag_z = (sub[W-1:0] == '0);
   assign flag_n = sub[W-1];
   assign flag_c = sub[W];
   assign flag_v = (a_i[W-1] ^ b_i[W-1]) & (sub[W-1] ^ a_i[W-1]);

   // Select the flag combination for the requested compare function
   always_comb begin
      res_o = 1'b0;
      case (fn_i)
         CMP_EQ:  res_o = flag_z;
         CMP_NE:  res_o = ~flag_z;
         CMP_GE:  res_o = ~(flag_n ^ flag_v);
         CMP_LT:  res_o = flag_n ^ flag_v;
         CMP_GTU: res_o = flag_c & ~flag_z;
         CMP_LTU: res_o = ~flag_c;
         CMP_GEU: res_o = flag_c;
         CMP_OVF: res_o = flag_v;
         default: res_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-port arbiter sharing one comparator between branch resolution (port 0)
// and SLT/SLTU (port 1), with a single registered result slot.
// Build option CMP_ARB_RR_EN: round-robin tie-break via last_grant; when
// undefined, port 0 always wins ties and no last_grant register exists.
module cmp_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int unsigned W = CMP_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         req0_valid_i,
   output logic         req0_ready_o,
   input  logic [W-1:0] req0_a_i,
   input  logic [W-1:0] req0_b_i,
   input  logic [2:0]   req0_fn_i,
   input  logic         req1_valid_i,
   output logic         req1_ready_o,
   input  logic [W-1:0] req1_a_i,
   input  logic [W-1:0] req1_b_i,
   input  logic [2:0]   req1_fn_i,
   output logic         resp0_valid_o,
   input  logic         resp0_ready_i,
   output logic         resp1_valid_o,
   input  logic         resp1_ready_i,
   output logic [W-1:0] resp_data_o,
   output logic         busy_o
);

   logic     full_q, full_d;
   port_id_t owner_q, owner_d;
   logic     bit_q, bit_d;
`ifdef CMP_ARB_RR_EN
   port_id_t last_grant_q, last_grant_d;
`endif

   logic         owner_rdy;
   logic         free;
   logic         grant_vld;
   port_id_t     grant;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [2:0]   op_fn;
   logic         cmp_bit;

   assign resp0_valid_o = full_q & (owner_q == PORT0);
   assign resp1_valid_o = full_q & (owner_q == PORT1);
   assign resp_data_o   = {{(W-1){1'b0}}, bit_q};
   assign busy_o        = full_q;

   // Slot can take a new result if empty or its owner consumes this cycle
   assign owner_rdy = (owner_q == PORT1) ? resp1_ready_i : resp0_ready_i;
   assign free      = ~full_q | (owner_rdy & full_q);

   // Pick a winner only when the slot frees and no reset/flush is pending
   always_comb begin
      grant_vld = 1'b0;
      grant     = PORT0;
      if (!rst && free && !flush_i) begin
         if (req0_valid_i && req1_valid_i) begin
            grant_vld = 1'b1;
`ifdef CMP_ARB_RR_EN
            grant     = ~last_grant_q;
`else
            grant     = PORT0;
`endif
         end else if (req0_valid_i) begin
            grant_vld = 1'b1;
            grant     = PORT0;
         end else if (req1_valid_i) begin
            grant_vld = 1'b1;
            grant     = PORT1;
         end
      end
   end

   assign req0_ready_o = grant_vld & (grant == PORT0);
   assign req1_ready_o = grant_vld & (grant == PORT1);

   assign op_a  = (grant == PORT1) ? req1_a_i  : req0_a_i;
   assign op_b  = (grant == PORT1) ? req1_b_i  : req0_b_i;
   assign op_fn = (grant == PORT1) ? req1_fn_i : req0_fn_i;

   cmp_core #(.W(W)) u_core (
      .a_i   (op_a),
      .b_i   (op_b),
      .fn_i  (op_fn),
      .res_o (cmp_bit)
   );

   // Slot next state: flush drops, accept (re)loads, consume empties
   always_comb begin
      full_d  = full_q;
      owner_d = owner_q;
      bit_d   = bit_q;
`ifdef CMP_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      if (flush_i) begin
         full_d = 1'b0;
      end else if (grant_vld) begin
         full_d  = 1'b1;
         owner_d = grant;
         bit_d   = cmp_bit;
`ifdef CMP_ARB_RR_EN
         last_grant_d = grant;
`endif
      end else if (free) begin
         full_d = 1'b0;
      end
   end

   // Slot and arbitration history registers
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q  <= 1'b0;
         owner_q <= PORT0;
         bit_q   <= 1'b0;
`ifdef CMP_ARB_RR_EN
         last_grant_q <= PORT1;
`endif
      end else begin
         full_q  <= full_d;
         owner_q <= owner_d;
         bit_q   <= bit_d;
`ifdef CMP_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: accepted requests push their expected
// {port, result} and a monitor pops/compares on every consumed response.
// Tie-break expectations follow CMP_ARB_RR_EN as compiled.
module tb_cmp_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic [2:0]  req0_fn_i, req1_fn_i;
   logic        resp0_valid_o, resp1_valid_o;
   logic        resp0_ready_i, resp1_ready_i;
   logic [31:0] resp_data_o;
   logic        busy_o;

   int checks = 0;
   int passed = 0;

   logic        exp0, exp1;
   logic [32:0] sbq[$];
   logic [32:0] dropped;

   always #5 clk = ~clk;

   cmp_arbiter #(.W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush_i),
      .req0_valid_i  (req0_valid_i),
      .req0_ready_o  (req0_ready_o),
      .req0_a_i      (req0_a_i),
      .req0_b_i      (req0_b_i),
      .req0_fn_i     (req0_fn_i),
      .req1_valid_i  (req1_valid_i),
      .req1_ready_o  (req1_ready_o),
      .req1_a_i      (req1_a_i),
      .req1_b_i      (req1_b_i),
      .req1_fn_i     (req1_fn_i),
      .resp0_valid_o (resp0_valid_o),
      .resp0_ready_i (resp0_ready_i),
      .resp1_valid_o (resp1_valid_o),
      .resp1_ready_i (resp1_ready_i),
      .resp_data_o   (resp_data_o),
      .busy_o        (busy_o)
   );

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fn, input logic e);
      req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; req0_fn_i = fn; exp0 = e;
   endtask

   task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fn, input logic e);
      req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; req1_fn_i = fn; exp1 = e;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   // Record accepts at the current sample point, then move to the next cycle
   task automatic adv;
      if (req0_valid_i && req0_ready_o) sbq.push_back({1'b0, 31'b0, exp0});
      if (req1_valid_i && req1_ready_o) sbq.push_back({1'b1, 31'b0, exp1});
      @(posedge clk);
      #1;
   endtask

   task automatic drop_front(input string name);
      if (sbq.size() == 0) chk(name, 33'd0, 33'd1);
      else dropped = sbq.pop_front();
   endtask

   // Monitor: every consumed response must match the oldest expectation
   always @(negedge clk) begin
      if (resp0_valid_o && resp1_valid_o) begin
         chk("resp_onehot", {31'b0, resp1_valid_o, resp0_valid_o}, 33'd1);
      end else if ((resp0_valid_o && resp0_ready_i) || (resp1_valid_o && resp1_ready_i)) begin
         if (sbq.size() == 0) chk("sb_unexpected", {resp1_valid_o, resp_data_o}, 33'h1_ffff_ffff);
         else chk("sb_resp", {resp1_valid_o, resp_data_o}, sbq.pop_front());
      end
   end

   logic [2:0] fnv [8];
   logic       fne [8];
   int         expg [4];

   initial begin
      fnv = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      fne = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef CMP_ARB_RR_EN
      expg = '{0, 1, 0, 1};
`else
      expg = '{0, 0, 0, 0};
`endif
      rst = 1'b1; flush_i = 1'b0;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      req0_a_i = '0; req0_b_i = '0; req0_fn_i = '0;
      req1_a_i = '0; req1_b_i = '0; req1_fn_i = '0;
      resp0_ready_i = 1'b1; resp1_ready_i = 1'b1;
      exp0 = 1'b0; exp1 = 1'b0;
      repeat (2) begin settle; adv; end
      rst = 1'b0;

      // Reset state
      settle;
      chk("rst_outs", {27'b0, resp0_valid_o, resp1_valid_o, busy_o, req0_ready_o, req1_ready_o, 1'b0}, 33'd0);
      chk("rst_data", {1'b0, resp_data_o}, 33'd0);
      adv;

      // Single req0 equality
      set0(32'd5, 32'd5, 3'b000, 1'b1);
      settle; chk("r0_ready", {32'b0, req0_ready_o}, 33'd1); adv;
      req0_valid_i = 1'b0;
      settle;
      chk("r0_valid", {31'b0, resp1_valid_o, resp0_valid_o}, 33'd1);
      chk("r0_data", {1'b0, resp_data_o}, 33'd1);
      adv;

      // Back-to-back req1 signed then unsigned compare
      set1(32'hFFFF_FFFF, 32'd1, 3'b011, 1'b1);
      settle; chk("r1_rdy_a", {32'b0, req1_ready_o}, 33'd1); adv;
      set1(32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0);
      settle; chk("r1_rdy_b", {32'b0, req1_ready_o}, 33'd1);
      chk("r1_valid_a", {32'b0, resp1_valid_o}, 33'd1); adv;
      req1_valid_i = 1'b0;
      settle; chk("r1_nobubble", {32'b0, resp1_valid_o}, 33'd1); adv;

      // Tie-break over four cycles
      set0(32'd1, 32'd2, 3'b101, 1'b1);
      set1(32'd1, 32'd2, 3'b110, 1'b0);
      for (int i = 0; i < 4; i++) begin
         settle;
         chk("tie_onehot", {32'b0, req0_ready_o ^ req1_ready_o}, 33'd1);
         chk($sformatf("tie_grant%0d", i), {32'b0, req1_ready_o}, expg[i][32:0]);
         adv;
      end
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      settle; adv;

      // Stall with pending req1, then free-and-accept in one cycle
      resp0_ready_i = 1'b0;
      set0(32'd3, 32'd7, 3'b100, 1'b0);
      settle; chk("st_acc", {32'b0, req0_ready_o}, 33'd1); adv;
      req0_valid_i = 1'b0;
      set1(32'd2, 32'd2, 3'b000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         settle;
         chk("st_hold", {28'b0, req0_ready_o, req1_ready_o, busy_o, resp0_valid_o, resp_data_o[0]}, 33'b0110);
         chk("st_data", {1'b0, resp_data_o}, 33'd0);
         adv;
      end
      resp0_ready_i = 1'b1;
      settle; chk("st_free_acc", {32'b0, req1_ready_o}, 33'd1); adv;
      req1_valid_i = 1'b0;
      settle; chk("st_r1_valid", {32'b0, resp1_valid_o}, 33'd1); adv;

      // Flush with a full slot and req0 waiting
      resp0_ready_i = 1'b0;
      set0(32'd9, 32'd4, 3'b001, 1'b1);
      settle; adv;
      set0(32'd9, 32'd4, 3'b011, 1'b0);
      flush_i = 1'b1;
      settle;
      chk("fl_noacc", {31'b0, req0_ready_o, resp0_valid_o}, 33'b01);
      drop_front("fl_drop");
      adv;
      flush_i = 1'b0; resp0_ready_i = 1'b1;
      settle;
      chk("fl_after", {31'b0, resp0_valid_o, req0_ready_o}, 33'b01);
      adv;
      req0_valid_i = 1'b0;
      settle; chk("fl_valid", {32'b0, resp0_valid_o}, 33'd1); adv;

      // Overflow result, then reset with a full slot
      resp0_ready_i = 1'b0;
      set0(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111, 1'b1);
      settle; adv;
      req0_valid_i = 1'b0;
      set1(32'd1, 32'd1, 3'b000, 1'b1);
      rst = 1'b1;
      settle;
      chk("ovf_data", {resp0_valid_o, resp_data_o}, {1'b1, 32'd1});
      chk("rst_noacc", {32'b0, req1_ready_o}, 33'd0);
      drop_front("rst_drop");
      adv;
      rst = 1'b0; req1_valid_i = 1'b0; resp0_ready_i = 1'b1;
      settle;
      chk("rst_mid", {28'b0, resp0_valid_o, resp1_valid_o, busy_o, req0_ready_o, req1_ready_o}, 33'd0);
      chk("rst_mid_data", {1'b0, resp_data_o}, 33'd0);
      adv;

      // All compare functions on a signed/unsigned boundary operand
      for (int i = 0; i < 8; i++) begin
         set1(32'h8000_0000, 32'd1, fnv[i], fne[i]);
         settle; chk($sformatf("fn%0d_rdy", i), {32'b0, req1_ready_o}, 33'd1); adv;
      end
      req1_valid_i = 1'b0;
      repeat (3) begin settle; adv; end

      chk("sb_empty", sbq.size(), 33'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
